branch_unit: RTL and testbench

Execute-stage control-transfer resolver for the 64-bit RISC-V core, directly downstream of the ALU. It consumes the ALU comparison flags and result, decides whether the instruction in execute redirects fetch, and owns the program counter register. It drives fetch with the current PC and issues a counted pipeline flush after every redirect.

---
 rtl/core_pkg.sv | 19 +
 rtl/branch_unit_if.sv | 45 ++++
 rtl/branch_unit_condition.sv | 31 +++
 rtl/branch_unit.sv | 97 +++++++++
 tb/tb_branch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: branch funct3 encodings, resolver FSM states and
// the instruction alignment used for sequential PC advance.
package core_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam int INSTR_ALIGN = 4;

endpackage

// File: rtl/branch_unit_if.sv
// Execute-stage <-> branch resolver bundle: ALU flags and operands in, fetch
// PC and pipeline-control pulses out. The slave side is the branch unit.
interface branch_unit_if #(
    parameter int WORDSIZE = 64
);

    logic                pc_enable;
    logic                branch_valid;
    logic                is_jal;
    logic                is_jalr;
    logic [2:0]          funct3;
    logic [WORDSIZE-1:0] ex_pc;
    logic [WORDSIZE-1:0] immediate;
    logic [WORDSIZE-1:0] alu_result;
    logic                flag_equal;
    logic                flag_not_equal;
    logic                flag_greater;
    logic                flag_less;
    logic                flag_u_equal;
    logic                flag_u_greater;
    logic                flag_u_less;

    logic [WORDSIZE-1:0] pc;
    logic [WORDSIZE-1:0] link_value;
    logic                redirect;
    logic                flush;
    logic                misaligned;

    modport master (
        output pc_enable, branch_valid, is_jal, is_jalr, funct3,
               ex_pc, immediate, alu_result,
               flag_equal, flag_not_equal, flag_greater, flag_less,
               flag_u_equal, flag_u_greater, flag_u_less,
        input  pc, link_value, redirect, flush, misaligned
    );

    modport slave (
        input  pc_enable, branch_valid, is_jal, is_jalr, funct3,
               ex_pc, immediate, alu_result,
               flag_equal, flag_not_equal, flag_greater, flag_less,
               flag_u_equal, flag_u_greater, flag_u_less,
        output pc, link_value, redirect, flush, misaligned
    );

endinterface

// File: rtl/branch_unit_condition.sv
// Maps a branch funct3 and the ALU comparison flags to a taken/not-taken
// condition. Purely combinational; reserved encodings are never taken.
module branch_condition
    import core_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       flag_equal_i,
    input  logic       flag_not_equal_i,
    input  logic       flag_greater_i,
    input  logic       flag_less_i,
    input  logic       flag_u_equal_i,
    input  logic       flag_u_greater_i,
    input  logic       flag_u_less_i,
    output logic       condition_o
);

    // NOTE: default first so every path assigns condition_o and no latch is inferred.
    always_comb begin
        condition_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  condition_o = flag_equal_i;
            F3_BNE:  condition_o = flag_not_equal_i;
            F3_BLT:  condition_o = flag_less_i;
            F3_BGE:  condition_o = flag_greater_i | flag_equal_i;
            F3_BLTU: condition_o = flag_u_less_i;
            F3_BGEU: condition_o = flag_u_greater_i | flag_u_equal_i;
            default: condition_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage control-transfer resolver: owns the fetch PC, decides redirects
// for branches/JAL/JALR and holds a counted flush after every redirect.
module branch_unit
    import core_pkg::*;
#(
    parameter int                  WORDSIZE     = 64,
    parameter logic [WORDSIZE-1:0] RESET_PC     = '0,
    parameter logic [WORDSIZE-1:0] TRAP_PC      = WORDSIZE'(64'h100),
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    branch_unit_if.slave  bus
);

    localparam logic [2:0]          FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [WORDSIZE-1:0] PC_STEP    = WORDSIZE'(INSTR_ALIGN);

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic [WORDSIZE-1:0] pc_q;
    logic                redirect_q;
    logic                flush_q;
    logic                misaligned_q;

    logic                condition;
    logic                take_d;
    logic [WORDSIZE-1:0] target_d;
    logic                target_misaligned_d;

    branch_condition u_condition (
        .funct3_i         (bus.funct3),
        .flag_equal_i     (bus.flag_equal),
        .flag_not_equal_i (bus.flag_not_equal),
        .flag_greater_i   (bus.flag_greater),
        .flag_less_i      (bus.flag_less),
        .flag_u_equal_i   (bus.flag_u_equal),
        .flag_u_greater_i (bus.flag_u_greater),
        .flag_u_less_i    (bus.flag_u_less),
        .condition_o      (condition)
    );

    // JALR wins over JAL, which wins over a conditional branch.
    assign take_d = bus.pc_enable && (state_q == RUN) &&
                    (bus.is_jalr || bus.is_jal || (bus.branch_valid && condition));
    assign target_d = bus.is_jalr ? (bus.alu_result & ~WORDSIZE'(1))
                                  : (bus.ex_pc + bus.immediate);
    assign target_misaligned_d = (target_d[1:0] != 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            pc_q         <= RESET_PC;
            redirect_q   <= 1'b0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            if (bus.pc_enable) begin
                case (state_q)
                    RUN: begin
                        if (take_d) begin
                            pc_q         <= target_misaligned_d ? TRAP_PC : target_d;
                            redirect_q   <= 1'b1;
                            misaligned_q <= target_misaligned_d;
                            flush_q      <= 1'b1;
                            cnt_q        <= FLUSH_LAST;
                            state_q      <= FLUSH;
                        end else begin
                            pc_q <= pc_q + PC_STEP;
                        end
                    end
                    FLUSH: begin
                        pc_q <= pc_q + PC_STEP;
                        if (cnt_q == 3'd0) begin
                            flush_q <= 1'b0;
                            state_q <= RUN;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.link_value = bus.ex_pc + PC_STEP;
    assign bus.redirect   = redirect_q;
    assign bus.flush      = flush_q;
    assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed-vector bench for branch_unit: reset, branch kinds, jumps, misaligned
// trap, stall during flush, PC wrap and reset during flush.
module tb_branch_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    branch_unit_if #(.WORDSIZE(64)) bus ();

    branch_unit #(
        .WORDSIZE     (64),
        .RESET_PC     (64'h0),
        .TRAP_PC      (64'h100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags order: {eq, ne, gt, lt, ueq, ugt, ult}
    task automatic set_flags(input logic [6:0] f);
        {bus.flag_equal, bus.flag_not_equal, bus.flag_greater, bus.flag_less,
         bus.flag_u_equal, bus.flag_u_greater, bus.flag_u_less} = f;
    endtask

    task automatic idle();
        bus.branch_valid = 1'b0;
        bus.is_jal       = 1'b0;
        bus.is_jalr      = 1'b0;
        bus.funct3       = 3'b000;
        bus.ex_pc        = '0;
        bus.immediate    = '0;
        bus.alu_result   = '0;
        set_flags(7'b0);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.pc_enable = 1'b0;
        idle();
        reset = 1'b1;
        step();
        chk("reset_pc", bus.pc, 64'h0);
        chk("reset_flush", {63'b0, bus.flush}, 64'h0);
        chk("reset_redirect", {63'b0, bus.redirect}, 64'h0);
        chk("reset_misaligned", {63'b0, bus.misaligned}, 64'h0);
        reset = 1'b0;
        bus.pc_enable = 1'b1;
        repeat (3) step();
        chk("seq_pc_after_3", bus.pc, 64'hC);
    endtask

    task automatic test_beq();
        bus.branch_valid = 1'b1;
        bus.funct3       = 3'b000;
        bus.ex_pc        = 64'h40;
        bus.immediate    = 64'h20;
        set_flags(7'b1000000);
        step();
        chk("beq_pc", bus.pc, 64'h60);
        chk("beq_redirect", {63'b0, bus.redirect}, 64'h1);
        chk("beq_flush1", {63'b0, bus.flush}, 64'h1);
        chk("beq_misaligned", {63'b0, bus.misaligned}, 64'h0);
        step();  // branch still presented: squashed
        chk("beq_squash_pc", bus.pc, 64'h64);
        chk("beq_redirect_pulse", {63'b0, bus.redirect}, 64'h0);
        chk("beq_flush2", {63'b0, bus.flush}, 64'h1);
        step();
        chk("beq_flush_end", {63'b0, bus.flush}, 64'h0);
        chk("beq_squash_pc2", bus.pc, 64'h68);
        chk("beq_squash_redirect", {63'b0, bus.redirect}, 64'h0);
        idle();
    endtask

    task automatic test_bne_not_taken();
        do_reset();
        repeat (4) step();
        chk("bne_start_pc", bus.pc, 64'h10);
        bus.branch_valid = 1'b1;
        bus.funct3       = 3'b001;
        bus.ex_pc        = 64'h10;
        bus.immediate    = 64'h80;
        set_flags(7'b1000000);
        step();
        chk("bne_pc", bus.pc, 64'h14);
        chk("bne_redirect", {63'b0, bus.redirect}, 64'h0);
        chk("bne_flush", {63'b0, bus.flush}, 64'h0);
        bus.funct3 = 3'b010;
        set_flags(7'b1111111);
        step();
        chk("f3_010_pc", bus.pc, 64'h18);
        chk("f3_010_redirect", {63'b0, bus.redirect}, 64'h0);
        idle();
    endtask

    task automatic test_jumps();
        // jalr with a simultaneously taken branch: jalr has priority
        bus.is_jalr      = 1'b1;
        bus.alu_result   = 64'h1001;
        bus.ex_pc        = 64'h200;
        bus.branch_valid = 1'b1;
        bus.funct3       = 3'b000;
        bus.immediate    = 64'h8;
        set_flags(7'b1000000);
        #1;
        chk("jalr_link", bus.link_value, 64'h204);
        step();
        chk("jalr_pc", bus.pc, 64'h1000);
        chk("jalr_redirect", {63'b0, bus.redirect}, 64'h1);
        chk("jalr_misaligned", {63'b0, bus.misaligned}, 64'h0);
        idle();
        repeat (2) step();
        chk("jalr_flush_end", {63'b0, bus.flush}, 64'h0);
        bus.is_jal    = 1'b1;
        bus.ex_pc     = 64'h40;
        bus.immediate = 64'h6;
        #1;
        chk("jal_link", bus.link_value, 64'h44);
        step();
        chk("jal_trap_pc", bus.pc, 64'h100);
        chk("jal_misaligned", {63'b0, bus.misaligned}, 64'h1);
        chk("jal_redirect", {63'b0, bus.redirect}, 64'h1);
        chk("jal_flush", {63'b0, bus.flush}, 64'h1);
        idle();
        step();
        chk("jal_misaligned_pulse", {63'b0, bus.misaligned}, 64'h0);
        chk("jal_pc_seq", bus.pc, 64'h104);
        step();
        chk("jal_flush_end", {63'b0, bus.flush}, 64'h0);
    endtask

    task automatic test_conditions();
        logic [3:0] f3_v   [8] = '{4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0110, 4'b0110, 4'b0111, 4'b0011};
        logic [6:0] flag_v [8] = '{7'b0001000, 7'b0010000, 7'b1000000, 7'b0001000,
                                   7'b0000001, 7'b0001000, 7'b0000100, 7'b1111111};
        logic       take_v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.branch_valid = 1'b1;
            bus.funct3       = f3_v[i][2:0];
            bus.ex_pc        = 64'h300;
            bus.immediate    = 64'h40;
            set_flags(flag_v[i]);
            step();
            chk($sformatf("cond_%0d_redirect", i), {63'b0, bus.redirect}, {63'b0, take_v[i]});
            idle();
            repeat (2) step();
        end
    endtask

    task automatic test_stall();
        bus.branch_valid = 1'b1;
        bus.funct3       = 3'b111;
        bus.ex_pc        = 64'h80;
        bus.immediate    = 64'h10;
        set_flags(7'b0000010);
        step();
        chk("bgeu_pc", bus.pc, 64'h90);
        chk("bgeu_flush", {63'b0, bus.flush}, 64'h1);
        idle();
        bus.pc_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_%0d_pc", i), bus.pc, 64'h90);
            chk($sformatf("stall_%0d_flush", i), {63'b0, bus.flush}, 64'h1);
            chk($sformatf("stall_%0d_redirect", i), {63'b0, bus.redirect}, 64'h0);
        end
        bus.pc_enable = 1'b1;
        step();
        chk("stall_resume_pc", bus.pc, 64'h94);
        chk("stall_resume_flush", {63'b0, bus.flush}, 64'h1);
        step();
        chk("stall_end_pc", bus.pc, 64'h98);
        chk("stall_end_flush", {63'b0, bus.flush}, 64'h0);
    endtask

    task automatic test_wrap();
        bus.is_jalr    = 1'b1;
        bus.alu_result = 64'hFFFF_FFFF_FFFF_FFF4;
        step();
        idle();
        chk("wrap_jump_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFF4);
        repeat (2) step();
        chk("wrap_pre_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc", bus.pc, 64'h0);
        chk("wrap_redirect", {63'b0, bus.redirect}, 64'h0);
    endtask

    task automatic test_reset_mid_flush();
        bus.branch_valid = 1'b1;
        bus.funct3       = 3'b000;
        bus.ex_pc        = 64'h40;
        bus.immediate    = 64'h20;
        set_flags(7'b1000000);
        step();
        idle();
        chk("rst_flush_pre", {63'b0, bus.flush}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_pc", bus.pc, 64'h0);
        chk("rst_async_flush", {63'b0, bus.flush}, 64'h0);
        chk("rst_async_redirect", {63'b0, bus.redirect}, 64'h0);
        step();
        reset = 1'b0;
        step();
        chk("rst_resume_pc", bus.pc, 64'h4);
        chk("rst_resume_flush", {63'b0, bus.flush}, 64'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.pc_enable = 1'b0;
        idle();
        test_reset();
        test_beq();
        test_bne_not_taken();
        test_jumps();
        test_conditions();
        test_stall();
        test_wrap();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
